// File: rtl/lcd_frame_refresher_pkg.sv
// lcd_pkg: shared constants and FSM state encoding for the LCD frame refresher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_LINE0  = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1  = 8'hC0;
  localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;
  localparam int         LCD_LINE_LEN   = 16;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_CHAR      = 3'd3,
    ST_GAP       = 3'd4
  } lcd_state_t;

  // Cursor-positioning command for the start of a line.
  function automatic logic [7:0] line_cmd(input logic line);
    return line ? LCD_CMD_LINE1 : LCD_CMD_LINE0;
  endfunction

endpackage

// File: rtl/lcd_frame_refresher_if.sv
// Byte handshake between the frame refresher and the text LCD controller.
// Latency: n/a (wires only).
// Backpressure: lcd_ready gates every lcd_valid pulse.
// Signals: lcd_init_done, lcd_ready (controller -> refresher);
//          lcd_valid, lcd_is_cmd, lcd_data (refresher -> controller).
interface lcd_frame_refresher_if;
  logic       lcd_init_done;
  logic       lcd_ready;
  logic       lcd_valid;
  logic       lcd_is_cmd;
  logic [7:0] lcd_data;

  modport master (
    input  lcd_init_done,
    input  lcd_ready,
    output lcd_valid,
    output lcd_is_cmd,
    output lcd_data
  );

  modport slave (
    output lcd_init_done,
    output lcd_ready,
    input  lcd_valid,
    input  lcd_is_cmd,
    input  lcd_data
  );
endinterface

// File: rtl/lcd_frame_buf.sv
// 2x16 shadow character buffer with per-line dirty tracking.
// Latency: write/clear visible on rd_char and dirty one cycle after the request.
// Backpressure: none; writes and clears are always accepted.
// Ports: clk, reset; wr_en/wr_addr/wr_char byte write; clr_req fill with spaces;
//        set_all marks both lines dirty; dirty_clr clears dirty bits (set wins);
//        rd_line/rd_col -> rd_char combinational read; dirty per-line flags.
module lcd_frame_buf
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       clr_req,
  input  logic       set_all,
  input  logic [1:0] dirty_clr,
  input  logic       rd_line,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic [1:0] dirty
);

  logic [31:0][7:0] mem;
  logic [1:0]       dirty_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= {32{LCD_CHAR_SPACE}};
    end else if (clr_req) begin
      mem <= {32{LCD_CHAR_SPACE}};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_char;
    end
  end

  assign rd_char = mem[{rd_line, rd_col}];

  always_comb begin
    dirty_set = 2'b00;
    if (clr_req || set_all) begin
      dirty_set = 2'b11;
    end else if (wr_en) begin
      dirty_set[wr_addr[4]] = 1'b1;
    end
  end

  // Set is OR-ed after the clear so an update landing on the line being
  // picked for replay is never dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty <= 2'b11;
    end else begin
      dirty <= (dirty & ~dirty_clr) | dirty_set;
    end
  end

endmodule

// File: rtl/lcd_frame_refresher.sv
// Replays dirty lines of a 2x16 shadow buffer to a text LCD controller.
// Latency: one pulse per 2 cycles minimum; 17 pulses (cursor cmd + 16 chars) per line.
// Backpressure: each pulse waits for lcd_ready; one dead cycle follows every pulse.
// Ports: clk, reset (async, active high); wr_en/wr_addr/wr_char byte write
//        ([4] line, [3:0] column); clr_req fills with spaces; lcd (master
//        modport) controller handshake; refresh_busy, frame_done status.
// Optional macro LCD_REFRESH_PERIODIC_EN: forces a full replay every
// REFRESH_CYCLES cycles while the controller is initialised.
module lcd_frame_refresher
  import lcd_pkg::*;
#(
  parameter int LINE_LEN       = 16,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [4:0]                   wr_addr,
  input  logic [7:0]                   wr_char,
  input  logic                         clr_req,
  lcd_frame_refresher_if.master        lcd,
  output logic                         refresh_busy,
  output logic                         frame_done
);

  if (LINE_LEN != LCD_LINE_LEN) begin : g_line_len_check
    $error("lcd_frame_refresher: address split requires LINE_LEN == 16");
  end
  if (REFRESH_CYCLES < 1) begin : g_refresh_check
    $error("lcd_frame_refresher: REFRESH_CYCLES must be at least 1");
  end

  lcd_state_t state, state_n, ret, ret_n;
  logic       line, line_n;
  logic [3:0] col, col_n;
  logic       busy_n, done_n, valid_n, is_cmd_n;
  logic [7:0] data_n;
  logic [1:0] dirty, dirty_clr;
  logic [7:0] rd_char;
  logic       refresh_tick;

`ifdef LCD_REFRESH_PERIODIC_EN
  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
  logic [31:0] refresh_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (lcd.lcd_init_done) begin
      refresh_cnt <= (refresh_cnt == REFRESH_LAST) ? '0 : refresh_cnt + 32'd1;
    end
  end

  assign refresh_tick = lcd.lcd_init_done && (refresh_cnt == REFRESH_LAST);
`else
  assign refresh_tick = 1'b0;
`endif

  // Holding both lines dirty while the controller is uninitialised means
  // the whole panel is repainted once it comes back.
  lcd_frame_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .clr_req   (clr_req),
    .set_all   (!lcd.lcd_init_done || refresh_tick),
    .dirty_clr (dirty_clr),
    .rd_line   (line),
    .rd_col    (col),
    .rd_char   (rd_char),
    .dirty     (dirty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_WAIT_INIT;
      ret            <= ST_IDLE;
      line           <= 1'b0;
      col            <= 4'd0;
      refresh_busy   <= 1'b0;
      frame_done     <= 1'b0;
      lcd.lcd_valid  <= 1'b0;
      lcd.lcd_is_cmd <= 1'b0;
      lcd.lcd_data   <= 8'h00;
    end else begin
      state          <= state_n;
      ret            <= ret_n;
      line           <= line_n;
      col            <= col_n;
      refresh_busy   <= busy_n;
      frame_done     <= done_n;
      lcd.lcd_valid  <= valid_n;
      lcd.lcd_is_cmd <= is_cmd_n;
      lcd.lcd_data   <= data_n;
    end
  end

  always_comb begin
    state_n   = state;
    ret_n     = ret;
    line_n    = line;
    col_n     = col;
    busy_n    = refresh_busy;
    done_n    = 1'b0;
    valid_n   = 1'b0;
    is_cmd_n  = lcd.lcd_is_cmd;
    data_n    = lcd.lcd_data;
    dirty_clr = 2'b00;

    if (!lcd.lcd_init_done) begin
      state_n = ST_WAIT_INIT;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ST_WAIT_INIT: state_n = ST_IDLE;
        ST_IDLE: begin
          if (dirty != 2'b00) begin
            line_n    = !dirty[0];
            dirty_clr = dirty[0] ? 2'b01 : 2'b10;
            busy_n    = 1'b1;
            state_n   = ST_CMD;
          end
        end
        ST_CMD: begin
          if (lcd.lcd_ready) begin
            valid_n  = 1'b1;
            is_cmd_n = 1'b1;
            data_n   = line_cmd(line);
            ret_n    = ST_CHAR;
            col_n    = 4'd0;
            state_n  = ST_GAP;
          end
        end
        ST_CHAR: begin
          if (lcd.lcd_ready) begin
            // Read at issue time so late writes to unsent columns still land.
            valid_n  = 1'b1;
            is_cmd_n = 1'b0;
            data_n   = rd_char;
            if (col == 4'(LINE_LEN - 1)) begin
              ret_n = ST_IDLE;
            end else begin
              col_n = col + 4'd1;
            end
            state_n = ST_GAP;
          end
        end
        ST_GAP: begin
          // Dead cycle lets the controller drop ready before we look again.
          state_n = ret;
          if (ret == ST_IDLE) begin
            busy_n = 1'b0;
            done_n = (dirty == 2'b00);
          end
        end
        default: state_n = ST_WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_refresher.sv
// Directed bench for lcd_frame_refresher with a simple controller model.
// Latency: n/a.
// Backpressure: controller model can hold ready low for a set number of cycles per pulse.
module tb_lcd_frame_refresher;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       clr_req;
  logic       refresh_busy;
  logic       frame_done;

  lcd_frame_refresher_if ifc ();

  lcd_frame_refresher #(
    .LINE_LEN       (16),
    .REFRESH_CYCLES (1000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_char      (wr_char),
    .clr_req      (clr_req),
    .lcd          (ifc),
    .refresh_busy (refresh_busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = -100;
  int ready_delay = 0;
  int hold_cnt = 0;
  int done_cnt = 0;
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];

  localparam logic [127:0] SPACES = {16{8'h20}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Controller model: logs pulses and optionally holds ready low afterwards.
  initial begin
    ifc.lcd_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) done_cnt++;
      if (ifc.lcd_valid === 1'b1) begin
        check("valid_while_ready", ifc.lcd_ready, 1);
        check("pulse_spacing", (cyc - last_cyc >= 2), 1);
        last_cyc = cyc;
        log_q.push_back({ifc.lcd_is_cmd, ifc.lcd_data});
      end
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) ifc.lcd_ready = 1'b1;
      end
      if (ifc.lcd_valid === 1'b1 && ready_delay > 0) begin
        ifc.lcd_ready = 1'b0;
        hold_cnt = ready_delay;
      end
    end
  end

  task automatic push_line(input logic line, input logic [127:0] text);
    exp_q.push_back({1'b1, line ? 8'hC0 : 8'h80});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b0, text[c*8 +: 8]});
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) check($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
    end
  endtask

  task automatic wait_done(input string tag, input int base, input int limit);
    int n = 0;
    while (done_cnt <= base && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt > base), 1);
  endtask

  task automatic wait_pulses(input string tag, input int count, input int limit);
    int n = 0;
    while (log_q.size() < count && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pulses_reached"}, (log_q.size() >= count), 1);
  endtask

  task automatic write_byte(input logic [4:0] a, input logic [7:0] ch);
    wr_en = 1'b1;
    wr_addr = a;
    wr_char = ch;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    logic [127:0] t;
    int base;
    int n;

    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_char = '0;
    clr_req = 1'b0;
    ifc.lcd_init_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", ifc.lcd_valid, 0);
    check("rst_is_cmd", ifc.lcd_is_cmd, 0);
    check("rst_data", ifc.lcd_data, 0);
    check("rst_busy", refresh_busy, 0);
    check("rst_done", frame_done, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("no_activity_before_init", log_q.size(), 0);

    // Initial full paint
    ifc.lcd_init_done = 1'b1;
    wait_pulses("init", 3, 50);
    check("busy_during_replay", refresh_busy, 1);
    wait_done("init", 0, 300);
    repeat (20) @(negedge clk);
    push_line(1'b0, SPACES);
    push_line(1'b1, SPACES);
    compare_log("init");
    check("init_one_frame_done", done_cnt, 1);
    check("idle_busy_low", refresh_busy, 0);

    // Single write to line 1 column 3
    log_q.delete(); exp_q.delete();
    base = done_cnt;
    write_byte(5'h13, 8'h4B);
    wait_done("write_k", base, 200);
    t = SPACES; t[3*8 +: 8] = 8'h4B;
    push_line(1'b1, t);
    compare_log("write_k");

    // Slow controller: ready low for 40 cycles after each pulse
    log_q.delete(); exp_q.delete();
    ready_delay = 40;
    base = done_cnt;
    write_byte(5'h00, 8'h5A);
    wait_done("slow", base, 3000);
    t = SPACES; t[7:0] = 8'h5A;
    push_line(1'b0, t);
    compare_log("slow");
    ready_delay = 0;
    repeat (50) @(negedge clk);

    // Writes during a line-0 replay at column 3
    log_q.delete(); exp_q.delete();
    base = done_cnt;
    write_byte(5'h00, 8'h20);
    wait_pulses("midwr", 4, 100);
    write_byte(5'h0A, 8'h41);
    write_byte(5'h01, 8'h42);
    wait_done("midwr", base, 400);
    repeat (10) @(negedge clk);
    t = SPACES; t[10*8 +: 8] = 8'h41;
    push_line(1'b0, t);
    t[1*8 +: 8] = 8'h42;
    push_line(1'b0, t);
    compare_log("midwr");
    check("midwr_single_done", done_cnt, base + 1);

    // Clear beats a simultaneous write
    log_q.delete(); exp_q.delete();
    base = done_cnt;
    clr_req = 1'b1;
    wr_en = 1'b1;
    wr_addr = 5'h05;
    wr_char = 8'h51;
    @(negedge clk);
    clr_req = 1'b0;
    wr_en = 1'b0;
    wait_done("clear", base, 300);
    push_line(1'b0, SPACES);
    push_line(1'b1, SPACES);
    compare_log("clear");

    // Init drop mid-replay, then full repaint
    log_q.delete(); exp_q.delete();
    write_byte(5'h00, 8'h4D);
    wait_pulses("drop", 5, 100);
    ifc.lcd_init_done = 1'b0;
    @(negedge clk);
    check("drop_busy_low", refresh_busy, 0);
    n = log_q.size();
    repeat (20) @(negedge clk);
    check("drop_pulses_stop", log_q.size(), n);
    log_q.delete();
    base = done_cnt;
    ifc.lcd_init_done = 1'b1;
    wait_done("reinit", base, 300);
    t = SPACES; t[7:0] = 8'h4D;
    push_line(1'b0, t);
    push_line(1'b1, SPACES);
    compare_log("reinit");

    // Idle behaviour after the last frame
    log_q.delete();
`ifdef LCD_REFRESH_PERIODIC_EN
    wait_pulses("periodic", 34, 1100);
`else
    repeat (1100) @(negedge clk);
    check("idle_silent", log_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_frame_refresher.md
Name: lcd_frame_refresher

Overview:
- 2x16 character shadow frame buffer with a byte write port on the application side.
- Drives the text LCD controller's byte handshake. Tracks a dirty bit per line and replays each dirty line to the panel: one cursor command (0x80 or 0xC0) followed by 16 character writes.
- Sits between application logic (Morse decoder, mode/status writers) and text_lcd_ctrl. It is the only master of that controller's data interface.

Parameters:
- LINE_LEN, 16, characters per line; the address split assumes 16.
- REFRESH_CYCLES, 5_000_000, forced-refresh period in clk cycles. Used only with LCD_REFRESH_PERIODIC_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write one buffer byte this cycle
- wr_addr  in  5  [4] = line, [3:0] = column
- wr_char  in  8  ASCII byte to store
- clr_req  in  1  fill the whole buffer with 0x20
- lcd_init_done  in  1  from controller: initialisation finished
- lcd_ready  in  1  from controller: data_ready
- lcd_valid  out  1  to controller data_valid; single-cycle pulse
- lcd_is_cmd  out  1  to controller is_cmd
- lcd_data  out  8  to controller data_in
- refresh_busy  out  1  high while a line replay is in progress
- frame_done  out  1  one-cycle pulse when no line is left dirty after a replay

Behaviour:
- Reset state:
  - All outputs are 0.
  - Buffer is filled with 0x20; dirty = 2'b11.
  - State = ST_WAIT_INIT; col = 0.
  - Reset mid-replay aborts immediately; no further pulses are issued.
- Buffer writes:
  - Synchronous on wr_en; the line's dirty bit is set the next cycle.
  - clr_req takes priority over a wr_en in the same cycle. It fills all 32 bytes with 0x20 and sets dirty = 2'b11.
- Dirty-bit priority: a set request (wr_en or clr_req) wins over the replay's clear when both hit the same line in the same cycle.
- ST_WAIT_INIT: go to ST_IDLE when lcd_init_done = 1. No output activity before that.
- ST_IDLE:
  - If dirty != 0, pick a line; line 0 has priority.
  - Clear that line's dirty bit, set refresh_busy, then go to ST_CMD.
- ST_CMD: when lcd_ready = 1, issue lcd_data = 0x80 (line 0) or 0xC0 (line 1) with lcd_is_cmd = 1 and lcd_valid = 1 for one cycle. Then go to ST_GAP, with return state ST_CHAR and col = 0.
- ST_CHAR: when lcd_ready = 1, issue lcd_data = buf[line][col] with lcd_is_cmd = 0 and lcd_valid = 1. Then go to ST_GAP.
  - The byte is read at issue time, so a write to an unsent column appears in this pass.
  - If col = 15, the return state is ST_IDLE; otherwise col increments.
- ST_GAP:
  - One dead cycle; lcd_ready is ignored. This guarantees no back-to-back valid pulses while the controller lowers ready.
  - Then go to the return state.
  - When returning to ST_IDLE: refresh_busy drops. frame_done pulses if dirty == 0 in that cycle.
- Handshake rules:
  - lcd_valid is asserted only in a cycle where lcd_ready = 1 is sampled.
  - lcd_data and lcd_is_cmd hold their value until the next issue.
- Cost: each line replay is exactly 17 pulses; minimum spacing between pulses is 2 cycles.
- Write during a replay to the same line: the dirty bit is re-set and the line is replayed again afterwards. No update is ever lost.
- lcd_init_done dropping in any state returns the block to ST_WAIT_INIT with dirty = 2'b11 and refresh_busy = 0.

Optional Feature:
- Macro: LCD_REFRESH_PERIODIC_EN.
- Defined: a 32-bit free-running counter runs. Each time it reaches REFRESH_CYCLES-1 it wraps to 0 and sets dirty = 2'b11. This re-syncs the panel after glitches. The counter counts only when lcd_init_done = 1.
- Undefined: no counter. A replay is triggered only by writes, clears, reset or re-init.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_CMD_LINE0 = 8'h80, LCD_CMD_LINE1 = 8'hC0, LCD_CHAR_SPACE = 8'h20
  - the state encoding ST_WAIT_INIT / ST_IDLE / ST_CMD / ST_CHAR / ST_GAP (3 bits)
  - LCD_LINE_LEN = 16
- One sub-module: lcd_frame_buf, the 32x8 register buffer with write/clear logic and per-line dirty set/clear arbitration. The sequencing FSM stays in lcd_frame_refresher.

Test Plan:
- Reset, then lcd_init_done = 1 with lcd_ready held at 1:
  - expect 34 pulses: 0x80, 16x 0x20, 0xC0, 16x 0x20;
  - exactly one frame_done pulse after the last one.
- Idle, then write 'K' (0x4B) to addr 5'h13:
  - only line 1 is replayed: 0xC0, 0x20, 0x20, 0x20, 0x4B, then 12x 0x20;
  - no 0x80 command is issued.
- Model the controller dropping lcd_ready for 40 cycles after each pulse:
  - no lcd_valid while ready = 0;
  - never two valid pulses within 2 cycles.
- During a line-0 replay at col 3:
  - write 'A' to col 10: it appears in the current pass.
  - write 'B' to col 1: line 0 replays a second time containing 'B'.
- clr_req and wr_en in the same cycle: buffer is all 0x20 and both lines replay. Drop lcd_init_done mid-replay: pulses stop, and a full 34-pulse replay follows re-init.
- With LCD_REFRESH_PERIODIC_EN and REFRESH_CYCLES = 1000: an idle panel replays both lines every 1000 cycles. Without the macro: no activity after the first frame_done.
